// File: rtl/fir_sample_source.sv
// Host-loaded sample FIFO that paces samples out to a FIR filter's X_input
// at a programmable rate, with sticky underrun/overflow status.
module fir_sample_source #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Wr_en,
  input  logic [DATA_W-1:0]      Wr_data,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic [DIV_W-1:0]       Rate_div,
  input  logic                   Clr_flags,
  output logic [DATA_W-1:0]      X_output,
  output logic                   X_valid,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Busy,
  output logic                   Underrun,
  output logic                   Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  cnt_next;
  logic [1:0]        rst_sync;
  logic              active;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              over_set;
  logic              pop;
  logic              under_set;

  // Reset asserts immediately but releases through two flops, so nothing
  // functional happens on the edges straight after Rst_n rises.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign active = rst_sync[1];
  assign Full   = (level == LW'(DEPTH));
  assign Level  = level;
  assign Busy   = (state == RUN);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Stop has priority over both Start and a pending tick; a tick with an
  // empty FIFO only raises Underrun and keeps streaming.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    under_set  = 1'b0;
    wr_accept  = active && Wr_en && !Full;
    over_set   = active && Wr_en && Full;
    if (active) begin
      case (state)
        IDLE: begin
          if (Start && !Stop) begin
            state_next = RUN;
            cnt_next   = Rate_div;
          end
        end
        RUN: begin
          if (Stop) begin
            state_next = IDLE;
          end else if (cnt == '0) begin
            cnt_next  = Rate_div;
            pop       = (level != '0);
            under_set = (level == '0);
          end else begin
            cnt_next = cnt - DIV_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_accept) - LW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_accept) mem[wr_ptr] <= Wr_data;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      X_output <= '0;
      X_valid  <= 1'b0;
    end else begin
      X_valid <= pop;
      if (pop) X_output <= mem[rd_ptr];
    end
  end

  // A setting event in the same cycle as Clr_flags leaves the flag set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Underrun <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (under_set)      Underrun <= 1'b1;
      else if (Clr_flags) Underrun <= 1'b0;
      if (over_set)       Overflow <= 1'b1;
      else if (Clr_flags) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_sample_source.sv
// Randomized and directed self-checking bench for fir_sample_source against a
// queue-based reference model that schedules ticks by absolute edge number.
module tb_fir_sample_source;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;

  logic            Clk;
  logic            Rst_n;
  logic            Wr_en;
  logic [DW-1:0]   Wr_data;
  logic            Start;
  logic            Stop;
  logic [DIVW-1:0] Rate_div;
  logic            Clr_flags;
  logic [DW-1:0]   X_output;
  logic            X_valid;
  logic            Full;
  logic [4:0]      Level;
  logic            Busy;
  logic            Underrun;
  logic            Overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_q[$];
  bit            m_run;
  longint        m_edge;
  longint        m_tick_at;
  logic [DW-1:0] m_xo;
  bit            m_xv;
  bit            m_und;
  bit            m_ovf;

  fir_sample_source #(.DATA_W(DW), .DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Wr_en(Wr_en), .Wr_data(Wr_data),
    .Start(Start), .Stop(Stop), .Rate_div(Rate_div), .Clr_flags(Clr_flags),
    .X_output(X_output), .X_valid(X_valid), .Full(Full), .Level(Level),
    .Busy(Busy), .Underrun(Underrun), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, m_edge, actual, expected);
    end
  endtask

  task automatic resetModel();
    m_q.delete();
    m_run = 0;
    m_xo  = '0;
    m_xv  = 0;
    m_und = 0;
    m_ovf = 0;
  endtask

  // One rising edge of the reference: pop decisions use the pre-edge occupancy.
  task automatic modelEdge(input bit wr, input logic [DW-1:0] d, input bit st,
                           input bit sp, input bit cl);
    int  pre_size;
    bit  und_set;
    bit  ovf_set;
    if (!Rst_n) begin
      resetModel();
      return;
    end
    pre_size = m_q.size();
    und_set  = 0;
    ovf_set  = wr && (pre_size == DEPTH);
    m_xv     = 0;
    if (m_run) begin
      if (sp) begin
        m_run = 0;
      end else if (m_edge == m_tick_at) begin
        m_tick_at = m_edge + longint'(Rate_div) + 1;
        if (pre_size > 0) begin
          m_xo = m_q.pop_front();
          m_xv = 1;
        end else begin
          und_set = 1;
        end
      end
    end else if (st && !sp) begin
      m_run     = 1;
      m_tick_at = m_edge + longint'(Rate_div) + 1;
    end
    if (wr && pre_size < DEPTH) m_q.push_back(d);
    m_und = und_set ? 1'b1 : (cl ? 1'b0 : m_und);
    m_ovf = ovf_set ? 1'b1 : (cl ? 1'b0 : m_ovf);
  endtask

  task automatic compareAll();
    checkOutput("x_valid",  32'(X_valid),  32'(m_xv));
    checkOutput("x_output", 32'(X_output), 32'(m_xo));
    checkOutput("level",    32'(Level),    32'(m_q.size()));
    checkOutput("full",     32'(Full),     32'(m_q.size() == DEPTH));
    checkOutput("busy",     32'(Busy),     32'(m_run));
    checkOutput("underrun", 32'(Underrun), 32'(m_und));
    checkOutput("overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  task automatic applyStimulus(input bit wr, input logic [DW-1:0] d, input bit st,
                               input bit sp, input bit cl);
    Wr_en = wr; Wr_data = d; Start = st; Stop = sp; Clr_flags = cl;
    @(posedge Clk);
    m_edge++;
    modelEdge(wr, d, st, sp, cl);
    #1;
    compareAll();
    Wr_en = 0; Start = 0; Stop = 0; Clr_flags = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0);
  endtask

  task automatic writeSample(input logic [DW-1:0] d);
    applyStimulus(1, d, 0, 0, 0);
  endtask

  task automatic releaseReset();
    Rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    Rst_n = 1'b1; Wr_en = 0; Wr_data = '0; Start = 0; Stop = 0;
    Rate_div = '0; Clr_flags = 0;
    m_edge = 0; m_tick_at = 0;
    resetModel();
    #2 Rst_n = 1'b0;
    #1 compareAll();
    idle(2);
    releaseReset();

    // Three samples at Rate_div=2, then underrun once drained
    Rate_div = 2;
    writeSample(3); writeSample(5); writeSample(7);
    applyStimulus(0, '0, 1, 0, 0);
    idle(13);
    applyStimulus(0, '0, 0, 1, 1);

    // Overfill by one, clear, then a write on a pop cycle of a full FIFO
    for (int i = 0; i < 17; i++) writeSample(DW'(100 + i));
    applyStimulus(0, '0, 0, 0, 1);
    Rate_div = 0;
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(1, 16'hBEEF, 0, 0, 0);
    idle(18);
    applyStimulus(0, '0, 0, 1, 1);

    // Back-to-back output at Rate_div=0
    for (int i = 0; i < 4; i++) writeSample(DW'(16'hA0 + i));
    applyStimulus(0, '0, 1, 0, 0);
    idle(6);
    applyStimulus(0, '0, 0, 1, 1);

    // Start+Stop together in IDLE; Stop landing on a tick cycle
    applyStimulus(0, '0, 1, 1, 0);
    writeSample(11); writeSample(22); writeSample(33);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    idle(4);
    applyStimulus(0, '0, 0, 1, 1);

    // Reset mid-stream with five entries queued
    Rate_div = 7;
    for (int i = 0; i < 5; i++) writeSample(DW'(50 + i));
    applyStimulus(0, '0, 1, 0, 0);
    idle(2);
    Rst_n = 1'b0;
    #1;
    resetModel();
    compareAll();
    idle(2);
    releaseReset();
    applyStimulus(0, '0, 1, 0, 0);
    idle(9);
    applyStimulus(0, '0, 0, 1, 1);

    // Random traffic with rate changes while streaming
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) Rate_div = DIVW'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 9) < 4, DW'($urandom_range(0, 65535)),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
